// File: rtl/sd_pkg.sv
// Shared constants, state encoding and scaling helpers for the three-phase
// sigma-delta decoder.
package sd_pkg;

    localparam int SD_IN_BW  = 16;
    localparam int DEC_LOG2  = 8;
    localparam int CIC_ORDER = 3;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } dec_state_e;

    // Integrator/comb width: order*log2(R) bits of gain plus sign and the +/-1 input.
    function automatic int reg_bw(input int dec_log2);
        return CIC_ORDER * dec_log2 + 2;
    endfunction

    // Arithmetic right shift followed by clamping to +/-(2^(out_bw-1)-1).
    function automatic logic signed [31:0] sat_shift(input logic signed [63:0] v,
                                                     input int shift,
                                                     input int out_bw);
        logic signed [63:0] s;
        logic signed [63:0] lim;
        s   = v >>> shift;
        lim = (64'sd1 <<< (out_bw - 1)) - 64'sd1;
        if (s > lim) begin
            s = lim;
        end else if (s < -lim) begin
            s = -lim;
        end
        return s[31:0];
    endfunction

endpackage

// File: rtl/sd_cic3_decim.sv
// One phase of the decoder: +/-1 mapping, three wrapping integrators, three
// tick-clocked combs and saturating output scaling.
module sd_cic3_decim #(
    parameter int SD_IN_BW = sd_pkg::SD_IN_BW,
    parameter int DEC_LOG2 = sd_pkg::DEC_LOG2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       tick,
    input  logic                       bit_in,
    output logic signed [SD_IN_BW-1:0] sample_next,
    output logic signed [SD_IN_BW-1:0] sample_q
);
    import sd_pkg::*;

    localparam int REG_BW = reg_bw(DEC_LOG2);
    localparam int SHIFT  = CIC_ORDER * DEC_LOG2 - (SD_IN_BW - 1);

    logic [REG_BW-1:0] x;
    logic [REG_BW-1:0] int1_q, int1_d, int2_q, int2_d, int3_q, int3_d;
    logic [REG_BW-1:0] dl1_q, dl1_d, dl2_q, dl2_d, dl3_q, dl3_d;
    logic [REG_BW-1:0] c1, c2, c3;
    logic signed [63:0] wide;
    logic signed [31:0] sat;
    logic signed [SD_IN_BW-1:0] sample_d;

    always_comb begin
        // bit 1 -> +1, bit 0 -> -1 (all ones)
        x = {{(REG_BW-1){~bit_in}}, 1'b1};

        int1_d = int1_q;
        int2_d = int2_q;
        int3_d = int3_q;
        if (en) begin
            int1_d = int1_q + x;
            int2_d = int2_q + int1_d;
            int3_d = int3_q + int2_d;
        end

        // Combs see the integrator value that already includes this cycle's bit.
        c1 = int3_d - dl1_q;
        c2 = c1 - dl2_q;
        c3 = c2 - dl3_q;

        wide        = {{(64-REG_BW){c3[REG_BW-1]}}, c3};
        sat         = sat_shift(wide, SHIFT, SD_IN_BW);
        sample_next = sat[SD_IN_BW-1:0];

        dl1_d    = dl1_q;
        dl2_d    = dl2_q;
        dl3_d    = dl3_q;
        sample_d = sample_q;
        if (tick) begin
            dl1_d    = int3_d;
            dl2_d    = c1;
            dl3_d    = c2;
            sample_d = sample_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int1_q   <= '0;
            int2_q   <= '0;
            int3_q   <= '0;
            dl1_q    <= '0;
            dl2_q    <= '0;
            dl3_q    <= '0;
            sample_q <= '0;
        end else begin
            int1_q   <= int1_d;
            int2_q   <= int2_d;
            int3_q   <= int3_d;
            dl1_q    <= dl1_d;
            dl2_q    <= dl2_d;
            dl3_q    <= dl3_d;
            sample_q <= sample_d;
        end
    end

endmodule

// File: rtl/three_phase_sd_decoder.sv
// Three-phase sigma-delta decoder: shared decimation counter, warmup FSM,
// valid strobe and imbalance flag around three CIC3 decimators.
module three_phase_sd_decoder #(
    parameter int SD_IN_BW   = sd_pkg::SD_IN_BW,
    parameter int DEC_LOG2   = sd_pkg::DEC_LOG2,
    parameter int IMB_THRESH = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       phaseA,
    input  logic                       phaseB,
    input  logic                       phaseC,
    output logic signed [SD_IN_BW-1:0] phaseAx,
    output logic signed [SD_IN_BW-1:0] phaseBx,
    output logic signed [SD_IN_BW-1:0] phaseCx,
    output logic                       valid,
    output logic                       imbalance
);
    import sd_pkg::*;

    localparam int SUM_BW = SD_IN_BW + 2;
    localparam logic [SUM_BW-1:0] THR = SUM_BW'(IMB_THRESH);

    logic [DEC_LOG2-1:0] cnt_q, cnt_d;
    logic                tick;
    dec_state_e          state_q, state_d;
    logic [1:0]          wcnt_q, wcnt_d;
    logic                valid_q, valid_d;
    logic                imb_q, imb_d;

    logic [2:0]                 bits;
    logic signed [SD_IN_BW-1:0] smp_next [3];
    logic signed [SD_IN_BW-1:0] smp_q    [3];
    logic signed [SUM_BW-1:0]   sum;
    logic [SUM_BW-1:0]          abs_sum;

    assign bits = {phaseC, phaseB, phaseA};

    for (genvar g = 0; g < 3; g++) begin : g_phase
        sd_cic3_decim #(
            .SD_IN_BW(SD_IN_BW),
            .DEC_LOG2(DEC_LOG2)
        ) u_cic (
            .clk        (clk),
            .rst        (rst),
            .en         (en),
            .tick       (tick),
            .bit_in     (bits[g]),
            .sample_next(smp_next[g]),
            .sample_q   (smp_q[g])
        );
    end

    assign tick = en && (cnt_q == '1);

    always_comb begin
        // Counter wraps naturally at R since R is a power of two.
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = cnt_q + 1'b1;
        end

        state_d = state_q;
        wcnt_d  = wcnt_q;
        valid_d = 1'b0;
        case (state_q)
            WARMUP: begin
                if (tick) begin
                    if (wcnt_q == 2'd2) begin
                        state_d = RUN;
                    end else begin
                        wcnt_d = wcnt_q + 2'd1;
                    end
                end
            end
            RUN: begin
                valid_d = tick;
            end
            default: state_d = WARMUP;
        endcase

        sum = {{2{smp_next[0][SD_IN_BW-1]}}, smp_next[0]}
            + {{2{smp_next[1][SD_IN_BW-1]}}, smp_next[1]}
            + {{2{smp_next[2][SD_IN_BW-1]}}, smp_next[2]};
        abs_sum = sum[SUM_BW-1] ? SUM_BW'(-sum) : SUM_BW'(sum);

        imb_d = imb_q;
        if (tick) begin
            imb_d = (abs_sum > THR);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            state_q <= WARMUP;
            wcnt_q  <= '0;
            valid_q <= 1'b0;
            imb_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            valid_q <= valid_d;
            imb_q   <= imb_d;
        end
    end

    assign phaseAx   = smp_q[0];
    assign phaseBx   = smp_q[1];
    assign phaseCx   = smp_q[2];
    assign valid     = valid_q;
    assign imbalance = imb_q;

endmodule

// File: tb/tb_three_phase_sd_decoder.sv
// Directed bench for three_phase_sd_decoder: periodic bit patterns with
// hand-computed decoded values, an enable gap, mid-run reset and a modulated feed.
module tb_three_phase_sd_decoder;

    logic clk = 1'b0;
    logic rst, en, phaseA, phaseB, phaseC;
    logic signed [15:0] phaseAx, phaseBx, phaseCx;
    logic valid, imbalance;

    three_phase_sd_decoder #(.SD_IN_BW(16), .DEC_LOG2(8), .IMB_THRESH(1024)) dut (
        .clk(clk), .rst(rst), .en(en),
        .phaseA(phaseA), .phaseB(phaseB), .phaseC(phaseC),
        .phaseAx(phaseAx), .phaseBx(phaseBx), .phaseCx(phaseCx),
        .valid(valid), .imbalance(imbalance)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] pa, pb, pc;   // bit k is the stream value at enabled cycle 4n+k
        int         ea, eb, ec;
        logic       eimb;
    } vec_t;

    int   n_pass = 0;
    int   n_tot  = 0;
    logic [3:0] pa, pb, pc;
    int   idx;
    bit   sd_mode;
    real  acc [3];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic step(input bit e);
        real u;
        logic b [3];
        en = e;
        if (sd_mode) begin
            for (int p = 0; p < 3; p++) begin
                u = 0.8 * $sin(6.283185307 * idx / 3000.0 + p * 2.094395102);
                b[p] = (acc[p] >= 0.0);
                if (e) acc[p] = acc[p] + u - (b[p] ? 1.0 : -1.0);
            end
            phaseA = b[0]; phaseB = b[1]; phaseC = b[2];
        end else begin
            phaseA = pa[idx % 4];
            phaseB = pb[idx % 4];
            phaseC = pc[idx % 4];
        end
        @(posedge clk);
        #1;
        if (e) idx++;
    endtask

    task automatic run_until_valid(input int budget, input int gap_at, input int gap_len,
                                   output int cyc);
        bit got;
        got = 0;
        cyc = 0;
        while (!got && cyc < budget) begin
            step(!(cyc >= gap_at && cyc < gap_at + gap_len));
            cyc++;
            if (valid) got = 1;
        end
        if (!got) cyc = -1;
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1; en = 1'b0; idx = 0;
        phaseA = 1'b0; phaseB = 1'b0; phaseC = 1'b0;
        for (int p = 0; p < 3; p++) acc[p] = 0.0;
        repeat (2) @(posedge clk);
        #1;
        chk({nm, "_rst_A"}, phaseAx, 0);
        chk({nm, "_rst_valid"}, valid, 0);
        chk({nm, "_rst_imb"}, imbalance, 0);
        rst = 1'b0;
    endtask

    vec_t vecs [6];
    int   c;
    longint s;

    initial begin
        vecs[0] = '{"all_one",  4'b1111, 4'b1111, 4'b1111,  32767,  32767,  32767, 1'b1};
        vecs[1] = '{"all_zero", 4'b0000, 4'b0000, 4'b0000, -32767, -32767, -32767, 1'b1};
        vecs[2] = '{"mixed_pat",4'b0101, 4'b0011, 4'b0111,      0,      0,  16384, 1'b1};
        vecs[3] = '{"balanced", 4'b1111, 4'b0000, 4'b0101,  32767, -32767,      0, 1'b0};
        vecs[4] = '{"half_bal", 4'b0111, 4'b0001, 4'b0101,  16384, -16384,      0, 1'b0};
        vecs[5] = '{"half_imb", 4'b0111, 4'b0111, 4'b0001,  16384,  16384, -16384, 1'b1};
        sd_mode = 0;

        foreach (vecs[i]) begin
            pa = vecs[i].pa; pb = vecs[i].pb; pc = vecs[i].pc;
            do_reset(vecs[i].name);
            run_until_valid(1100, -1, 0, c);
            chk({vecs[i].name, "_first_valid_cycle"}, c, 1024);
            chk({vecs[i].name, "_A"}, phaseAx, vecs[i].ea);
            chk({vecs[i].name, "_B"}, phaseBx, vecs[i].eb);
            chk({vecs[i].name, "_C"}, phaseCx, vecs[i].ec);
            chk({vecs[i].name, "_imb"}, imbalance, vecs[i].eimb);
            step(1'b1);
            chk({vecs[i].name, "_valid_one_cycle"}, valid, 0);
            chk({vecs[i].name, "_hold_A"}, phaseAx, vecs[i].ea);
            run_until_valid(300, -1, 0, c);
            chk({vecs[i].name, "_period"}, c + 1, 256);
            chk({vecs[i].name, "_A2"}, phaseAx, vecs[i].ea);
            chk({vecs[i].name, "_C2"}, phaseCx, vecs[i].ec);
        end

        // Enable gap before the first strobe: pure delay, identical values.
        pa = vecs[2].pa; pb = vecs[2].pb; pc = vecs[2].pc;
        do_reset("gap");
        run_until_valid(1300, 500, 100, c);
        chk("gap_first_valid_cycle", c, 1124);
        chk("gap_A", phaseAx, 0);
        chk("gap_C", phaseCx, 16384);
        chk("gap_imb", imbalance, 1);

        // En gap mid-period while in RUN.
        run_until_valid(500, 100, 100, c);
        chk("gap_run_period", c, 356);
        chk("gap_run_C", phaseCx, 16384);

        // One-cycle reset mid-period in RUN.
        repeat (100) step(1'b1);
        rst = 1'b1;
        #2;
        chk("midrst_async_C", phaseCx, 0);
        chk("midrst_async_imb", imbalance, 0);
        @(posedge clk);
        #1;
        chk("midrst_valid", valid, 0);
        chk("midrst_A", phaseAx, 0);
        rst = 1'b0;
        idx = 0;
        run_until_valid(1100, -1, 0, c);
        chk("midrst_first_valid_cycle", c, 1024);
        chk("midrst_C", phaseCx, 16384);

        // Balanced three-phase sigma-delta feed.
        sd_mode = 1;
        do_reset("sd");
        run_until_valid(1100, -1, 0, c);
        chk("sd_first_valid_cycle", c, 1024);
        for (int k = 0; k < 8; k++) begin
            run_until_valid(300, -1, 0, c);
            chk("sd_period", c, 256);
            s = longint'(phaseAx) + longint'(phaseBx) + longint'(phaseCx);
            if (s < 0) s = -s;
            chk("sd_sum_in_bound", (s <= 1024), 1);
            chk("sd_imb", imbalance, 0);
        end
        sd_mode = 0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/three_phase_sd_decoder.md
Name: three_phase_sd_decoder

Overview:
Receive-side counterpart of the three-phase sigma-delta generator. It takes the three 1-bit sigma-delta streams phaseA, phaseB and phaseC and recovers signed multi-bit phase samples in the same SD_IN_BW format the generator consumes. Each stream passes through a 3rd-order CIC decimator with decimation ratio 2^DEC_LOG2. The block also flags three-phase imbalance and sits between the bitstream link and downstream control/monitoring logic.

Parameters:
SD_IN_BW, 16, output sample width (signed), matches generator input width
DEC_LOG2, 8, log2 of decimation ratio R; constraint 3*DEC_LOG2 >= SD_IN_BW-1
IMB_THRESH, 1024, imbalance threshold on |A+B+C| in output LSBs
localparam REG_BW = 3*DEC_LOG2 + 2, CIC integrator/comb width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  bit-sample enable; low = freeze all state
phaseA  in  1  sigma-delta stream phase A
phaseB  in  1  sigma-delta stream phase B
phaseC  in  1  sigma-delta stream phase C
phaseAx  out  SD_IN_BW  decoded phase A, signed
phaseBx  out  SD_IN_BW  decoded phase B, signed
phaseCx  out  SD_IN_BW  decoded phase C, signed
valid  out  1  one-cycle strobe, new phase*x samples
imbalance  out  1  |phaseAx+phaseBx+phaseCx| > IMB_THRESH for current sample

Behaviour:
- Reset (async, active-high): all integrators, comb delays, decimation counter, warmup counter cleared; state=WARMUP; phaseAx/Bx/Cx=0, valid=0, imbalance=0.
- Input mapping: bit 1 -> +1, bit 0 -> -1, sign-extended to REG_BW.
- Integrators: 3 cascaded per phase, updated every cycle with en=1; two's-complement wraparound in REG_BW is intended and must not saturate.
- Decimation counter: 0..R-1, increments when en=1. tick = (count==R-1)&&en; wraps to 0 on tick.
- On tick: integrator-3 output, including this cycle's input, feeds 3 cascaded combs (M=1, differential delay 1). Comb delay registers update only on tick.
- Output scaling: y = comb_out >>> (3*DEC_LOG2-(SD_IN_BW-1)). Saturate to the symmetric range ±(2^(SD_IN_BW-1)-1), e.g. ±32767 for 16 bits.
- Output timing: outputs, imbalance and valid are registered on the tick edge. valid is high exactly the cycle after a tick, otherwise 0. phase*x hold between strobes.
- State machine: WARMUP counts ticks 0..2 with valid suppressed (outputs still update internally). The 3rd tick moves to RUN. The first valid strobe is on the 4th tick after reset, then one every R enabled cycles.
- Imbalance: sum computed at SD_IN_BW+2 width from the saturated values; the flag is registered with the outputs and holds until the next strobe.
- en=0: nothing changes, including counters; valid=0 in that cycle. A tick requires en=1.
- rst mid-operation: immediate clear regardless of state; warmup restarts.

Decomposition:
- Shared package sd_pkg: SD_IN_BW, DEC_LOG2, the REG_BW function, the CIC order constant (3), and the saturating shift function.
- One sub-module, sd_cic3_decim: one phase (1-bit in, integrators, combs, scaling/saturation), instantiated 3×.
- Top holds the shared decimation counter, tick, warmup FSM, valid and imbalance logic.

Test Plan:
- All three streams constant 1, en=1, DEC_LOG2=8 -> first valid at cycle 4*256 after reset; phaseAx=Bx=Cx=32767; imbalance=1.
- Constant 0 on all streams -> outputs -32767; imbalance=1.
- Alternating 1,0 on A, 1,1,0,0 on B, 1,1,1,0 on C -> A=0, B=0, C=16384 (exact after warmup); imbalance=1 (C > 1024).
- Feed the bitstreams produced by the three-phase generator at a fixed omega -> decoded A+B+C within ±IMB_THRESH; imbalance=0; valid period exactly 256 cycles.
- en low for 100 cycles mid-period -> valid delayed by exactly 100 cycles; output values identical to the run without the gap.
- Assert rst for 1 cycle mid-period in RUN -> all outputs 0, valid=0 next edge; the first new valid arrives 4*256 enabled cycles after release.
